// File: rtl/bitplane_block_packer.sv
// Pixel-stream to bit-plane block packer: buffers BLK_PIX pixels, then emits one
// block per bit plane, each tagged with plane number, block index and plane key.
module bitplane_block_packer #(
    parameter int BLK_PIX    = 256,
    parameter int FRAME_BLKS = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         pix,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [21:0]        key_in,
    output logic [BLK_PIX-1:0] blk,
    output logic [3:0]         blk_plane,
    output logic [21:0]        blk_key,
    output logic [7:0]         blk_idx,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic               frame_done
);

    localparam int PW = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;

    typedef enum logic {
        S_FILL = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t             state_r;
    logic [PW-1:0]      pcnt_r;
    logic [7:0]         bcnt_r;
    logic [17:0]        key_lat_r;
    // Buffer is stored plane-major so a whole plane block is one read
    logic [BLK_PIX-1:0] planes_r [8];

    logic               pix_xfer_s;
    logic               blk_xfer_s;
    logic               last_pix_s;
    logic [PW-1:0]      wr_pos_s;
    logic [17:0]        key_sel_s;
    logic [BLK_PIX-1:0] first_blk_s;
    logic               key_lsb_unused_s;

    assign key_lsb_unused_s = ^key_in[3:0];

    // Handshake qualifiers and write position of the current pixel
    always_comb begin
        pix_xfer_s = pix_valid & pix_ready & (state_r == S_FILL);
        blk_xfer_s = blk_valid & blk_ready & (state_r == S_EMIT);
        last_pix_s = (pcnt_r == PW'(BLK_PIX - 1));
        wr_pos_s   = PW'(BLK_PIX - 1) - pcnt_r;
        if ((pcnt_r == {PW{1'b0}}) && (bcnt_r == 8'd0)) begin
            key_sel_s = key_in[21:4];
        end else begin
            key_sel_s = key_lat_r;
        end
    end

    // Plane 1 block including the pixel being accepted on this edge
    always_comb begin
        first_blk_s           = planes_r[0];
        first_blk_s[wr_pos_s] = pix[0];
    end

    // Scatter each accepted pixel's bits into the eight plane rows
    always_ff @(posedge clk) begin
        if (rst_n && pix_xfer_s) begin
            for (int b = 0; b < 8; b++) begin
                planes_r[b][wr_pos_s] <= pix[b];
            end
        end
    end

    // Control FSM with registered handshake and block outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_FILL;
            pcnt_r     <= {PW{1'b0}};
            bcnt_r     <= 8'd0;
            key_lat_r  <= 18'd0;
            pix_ready  <= 1'b0;
            blk_valid  <= 1'b0;
            blk        <= {BLK_PIX{1'b0}};
            blk_plane  <= 4'd1;
            blk_key    <= 22'd0;
            blk_idx    <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_r)
                S_FILL: begin
                    pix_ready <= 1'b1;
                    blk_valid <= 1'b0;
                    if (pix_xfer_s) begin
                        key_lat_r <= key_sel_s;
                        if (last_pix_s) begin
                            pcnt_r    <= {PW{1'b0}};
                            state_r   <= S_EMIT;
                            pix_ready <= 1'b0;
                            blk_valid <= 1'b1;
                            blk       <= first_blk_s;
                            blk_plane <= 4'd1;
                            blk_key   <= {key_sel_s, 4'd1};
                            blk_idx   <= bcnt_r;
                        end else begin
                            pcnt_r <= pcnt_r + PW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (blk_xfer_s) begin
                        if (blk_plane == 4'd8) begin
                            state_r   <= S_FILL;
                            blk_valid <= 1'b0;
                            pix_ready <= 1'b1;
                            blk_plane <= 4'd1;
                            if (bcnt_r == 8'(FRAME_BLKS - 1)) begin
                                bcnt_r     <= 8'd0;
                                frame_done <= 1'b1;
                            end else begin
                                bcnt_r <= bcnt_r + 8'd1;
                            end
                        end else begin
                            // Current plane n selects row n, i.e. plane n+1
                            blk       <= planes_r[blk_plane[2:0]];
                            blk_plane <= blk_plane + 4'd1;
                            blk_key   <= {key_lat_r, blk_plane + 4'd1};
                        end
                    end
                end
                default: begin
                    state_r   <= S_FILL;
                    pcnt_r    <= {PW{1'b0}};
                    pix_ready <= 1'b0;
                    blk_valid <= 1'b0;
                    blk_plane <= 4'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitplane_block_packer.sv
// Directed bench for bitplane_block_packer: table-driven block runs plus
// full-frame reassembly, key latching and mid-emit reset sequences.
module tb_bitplane_block_packer;

    localparam logic [21:0]  KA       = 22'b1101001110000110010001;
    localparam logic [21:0]  KB       = 22'h0F0F0F;
    localparam logic [21:0]  KC       = 22'h2AAAAA;
    localparam logic [21:0]  KEY_P1   = 22'b1101001110000110010001;
    localparam logic [21:0]  KEY_P8   = 22'b1101001110000110011000;
    localparam logic [255:0] PLANE1_0 = {64{4'h5}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   pix = 8'd0;
    logic         pix_valid = 1'b0;
    logic         pix_ready;
    logic [21:0]  key_in = KA;
    logic [255:0] blk;
    logic [3:0]   blk_plane;
    logic [21:0]  blk_key;
    logic [7:0]   blk_idx;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic         frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitplane_block_packer #(.BLK_PIX(256), .FRAME_BLKS(256)) dut (
        .clk(clk), .rst_n(rst_n), .pix(pix), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .key_in(key_in), .blk(blk), .blk_plane(blk_plane),
        .blk_key(blk_key), .blk_idx(blk_idx), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .frame_done(frame_done)
    );

    typedef struct {
        logic       first;
        logic       rdy;
        logic       exp_valid;
        logic [3:0] exp_plane;
        logic       exp_prdy;
        logic [7:0] exp_idx;
        int         run;
    } vec_t;

    vec_t vec [26];

    logic [7:0] mem   [65536];
    logic [7:0] recon [65536];
    bit mon_en    = 1'b0;
    bit fd_expect = 1'b0;
    int mon_cnt   = 0;
    int fd_cnt    = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] px(input int run, input int i);
        case (run)
            0:       return 8'(i);
            1:       return 8'((i * 37 + 11) & 255);
            default: return 8'(i) ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [255:0] plane_blk(input int run, input int plane);
        logic [255:0] r;
        logic [7:0]   v;
        for (int i = 0; i < 256; i++) begin
            v          = px(run, i);
            r[255 - i] = v[plane - 1];
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic first, input logic rdy, input logic valid,
                                input int plane, input logic prdy, input int idx, input int run);
        vec_t v;
        v.first     = first;
        v.rdy       = rdy;
        v.exp_valid = valid;
        v.exp_plane = 4'(plane);
        v.exp_prdy  = prdy;
        v.exp_idx   = 8'(idx);
        v.run       = run;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_pixel(input logic [7:0] v);
        int guard = 0;
        pix       = v;
        pix_valid = 1'b1;
        while (!pix_ready && guard < 64) begin
            step();
            guard++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL pix_ready_wait: got 0 expected 1 within 64 cycles");
        end
        step();
    endtask

    task automatic feed_run(input int run, input bit chg);
        for (int i = 0; i < 256; i++) begin
            if (chg && i == 100) key_in = KB;
            feed_pixel(px(run, i));
        end
        pix = 8'hAA;
    endtask

    // Full-frame scoreboard: checks every accepted block and the frame_done pulse
    always @(negedge clk) begin
        if (mon_en) begin
            int b;
            int p;
            if (fd_expect || frame_done) chk("frame_done_timing", frame_done, fd_expect);
            if (frame_done) fd_cnt++;
            fd_expect = 1'b0;
            if (blk_valid && blk_ready) begin
                b = mon_cnt >> 3;
                p = (mon_cnt & 7) + 1;
                chk("frame_plane", blk_plane, p);
                chk("frame_idx", blk_idx, b & 255);
                chk("frame_key", blk_key, {KA[21:4], 4'(p)});
                for (int i = 0; i < 256; i++) recon[b * 256 + i][p - 1] = blk[255 - i];
                if (mon_cnt == 2047) fd_expect = 1'b1;
                mon_cnt++;
            end
        end
    end

    initial begin
        int bp_plane [16] = '{1, 1, 1, 2, 3, 3, 3, 4, 5, 5, 5, 6, 7, 7, 7, 8};
        int bad;
        logic [7:0] v;

        for (int k = 0; k < 8; k++) vec[k] = mk(k == 0, 1'b1, 1'b1, k + 1, 1'b0, 0, 0);
        vec[8] = mk(1'b0, 1'b1, 1'b0, 1, 1'b1, 0, 0);
        for (int k = 0; k < 16; k++)
            vec[9 + k] = mk(k == 0, (k % 4) >= 2, 1'b1, bp_plane[k], 1'b0, 1, 1);
        vec[25] = mk(1'b0, 1'b1, 1'b0, 1, 1'b1, 1, 1);

        // Reset held for three cycles
        repeat (3) step();
        chk("rst_pix_ready", pix_ready, 1'b0);
        chk("rst_blk_valid", blk_valid, 1'b0);
        chk("rst_blk", blk, 256'd0);
        chk("rst_blk_plane", blk_plane, 4'd1);
        chk("rst_blk_key", blk_key, 22'd0);
        chk("rst_blk_idx", blk_idx, 8'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        step();
        chk("post_rst_pix_ready", pix_ready, 1'b1);
        chk("post_rst_blk_valid", blk_valid, 1'b0);

        // Table runs: run 0 with steady ready, run 1 with 2-on/2-off backpressure
        blk_ready = 1'b1;
        for (int e = 0; e < 26; e++) begin
            if (vec[e].first) begin
                blk_ready = 1'b1;
                feed_run(vec[e].run, vec[e].run == 1);
            end
            chk($sformatf("tbl%0d_valid", e), blk_valid, vec[e].exp_valid);
            chk($sformatf("tbl%0d_plane", e), blk_plane, vec[e].exp_plane);
            chk($sformatf("tbl%0d_pix_ready", e), pix_ready, vec[e].exp_prdy);
            if (vec[e].exp_valid) begin
                chk($sformatf("tbl%0d_idx", e), blk_idx, vec[e].exp_idx);
                chk($sformatf("tbl%0d_blk", e), blk, plane_blk(vec[e].run, vec[e].exp_plane));
                chk($sformatf("tbl%0d_key", e), blk_key, {KA[21:4], vec[e].exp_plane});
                if (vec[e].run == 0 && vec[e].exp_plane == 4'd1) begin
                    chk("run0_plane1_pattern", blk, PLANE1_0);
                    chk("run0_plane1_key", blk_key, KEY_P1);
                end
                if (vec[e].run == 0 && vec[e].exp_plane == 4'd8)
                    chk("run0_plane8_key", blk_key, KEY_P8);
                blk_ready = vec[e].rdy;
                step();
            end
        end

        // Full frame of random pixels, key changed at block 0 pixel 100 and block 5
        pix_valid = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
        step();
        key_in    = KA;
        blk_ready = 1'b1;
        mon_en    = 1'b1;
        for (int b = 0; b < 256; b++) begin
            if (b == 5) key_in = KC;
            for (int i = 0; i < 256; i++) begin
                v = 8'($urandom_range(0, 255));
                mem[b * 256 + i] = v;
                if (b == 0 && i == 100) key_in = KB;
                feed_pixel(v);
            end
        end
        pix_valid = 1'b0;
        repeat (12) step();
        mon_en = 1'b0;
        chk("frame_block_count", mon_cnt, 2048);
        chk("frame_done_count", fd_cnt, 1);
        bad = 0;
        for (int i = 0; i < 65536; i++) if (recon[i] !== mem[i]) bad++;
        chk("frame_reassembly_bad_pixels", bad, 0);

        // Reset while plane 4 of block 1 is being offered
        blk_ready = 1'b1;
        feed_run(0, 1'b0);
        repeat (8) step();
        chk("midop_fill_valid", blk_valid, 1'b0);
        chk("midop_fill_pix_ready", pix_ready, 1'b1);
        feed_run(1, 1'b0);
        chk("midop_idx1", blk_idx, 8'd1);
        repeat (3) step();
        chk("midop_plane4", blk_plane, 4'd4);
        chk("midop_plane4_valid", blk_valid, 1'b1);
        pix_valid = 1'b0;
        blk_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        chk("midop_rst_valid", blk_valid, 1'b0);
        chk("midop_rst_plane", blk_plane, 4'd1);
        chk("midop_rst_pix_ready", pix_ready, 1'b0);
        rst_n = 1'b1;
        step();
        chk("midop_release_pix_ready", pix_ready, 1'b1);
        key_in    = KC;
        blk_ready = 1'b1;
        feed_run(2, 1'b0);
        pix_valid = 1'b0;
        chk("fresh_valid", blk_valid, 1'b1);
        chk("fresh_plane", blk_plane, 4'd1);
        chk("fresh_idx", blk_idx, 8'd0);
        chk("fresh_blk", blk, plane_blk(2, 1));
        chk("fresh_key", blk_key, {KC[21:4], 4'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitplane_block_packer.md
Name: bitplane_block_packer

Overview:
- Upstream feeder for the cipher core: accepts an 8-bit pixel stream, collects runs of BLK_PIX pixels and slices each run into 8 bit-plane blocks of BLK_PIX bits.
- Emits the blocks one per plane over a valid/ready handshake.
- Tags each block with its plane number and the plane-specific private key {key[21:4], plane}, which the cipher consumes directly.

Parameters:
- BLK_PIX, 256, pixels per block = width of plane block (cipher data width).
- FRAME_BLKS, 256, blocks per frame (256 x 256 = 65536 pixels).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- pix  in  8  pixel data.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  packer accepts pixel this cycle.
- key_in  in  22  private key; bits [21:4] used.
- blk  out  BLK_PIX  plane block; bit BLK_PIX-1 = first pixel of run.
- blk_plane  out  4  plane number 1..8 (plane n = pixel bit n-1).
- blk_key  out  22  {key_lat[21:4], blk_plane}.
- blk_idx  out  8  block index in frame, 0..FRAME_BLKS-1.
- blk_valid  out  1  block present.
- blk_ready  in  1  downstream accepts block.
- frame_done  out  1  one-cycle pulse after the last block of a frame is accepted.

Behaviour:
- Storage is a pixel buffer of BLK_PIX x 8 bits. Pixel counter pcnt (0..BLK_PIX-1), plane counter (1..8), block counter bcnt (0..FRAME_BLKS-1), key latch key_lat[21:4].
- Reset (rst_n=0 at posedge), all outputs and counters forced as follows:
  - state=FILL, pcnt=0, plane=1, bcnt=0.
  - pix_ready=0 on the reset cycle, 1 from the first cycle after.
  - blk_valid=0, blk=0, blk_plane=1, blk_key=0, blk_idx=0, frame_done=0, key_lat=0.
  - Reset mid-FILL or mid-EMIT discards the partial buffer, and no block is emitted.
- FILL state:
  - pix_ready=1 and blk_valid=0.
  - A transfer occurs when pix_valid & pix_ready. The pixel is written to buffer slot pcnt and pcnt increments.
  - On the transfer with pcnt=0 and bcnt=0, key_in[21:4] is latched into key_lat. The key is constant for a whole frame; changes to key_in mid-frame are ignored.
  - On the transfer with pcnt=BLK_PIX-1: pcnt wraps to 0, state goes to EMIT, plane=1.
- EMIT state:
  - pix_ready=0 and blk_valid=1.
  - blk[BLK_PIX-1-i] = buffer[i][plane-1] for i = 0..BLK_PIX-1.
  - blk, blk_plane, blk_key and blk_idx are stable while blk_valid & !blk_ready.
  - On blk_valid & blk_ready with plane<8: plane increments, and the next plane appears on the following cycle.
  - On blk_valid & blk_ready with plane=8: plane=1, state returns to FILL, bcnt increments. If bcnt was FRAME_BLKS-1, bcnt wraps to 0 and frame_done pulses high in the next cycle only.
- Latency:
  - First block valid on the cycle after the BLK_PIX-th pixel is accepted.
  - A full run costs BLK_PIX + 8 cycles minimum with continuous valid/ready.
  - Pixel acceptance resumes on the cycle after plane 8 is accepted.
- Simultaneous events:
  - pix_valid in EMIT is ignored (not accepted, no data loss upstream since pix_ready=0).
  - blk_ready in FILL has no effect.
  - rst_n=0 dominates all other inputs.
- Widths: pcnt is log2(BLK_PIX) bits, bcnt is 8 bits. Wrap is explicit, never implicit overflow beyond FRAME_BLKS-1.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, then release -> all outputs at reset values; pix_ready=1 on the first cycle after release; blk_valid=0.
- Single run, key_in=22'b1101001110000110010001: feed pixels 0,1,...,255 with blk_ready=1. Required response:
  - Eight blocks arrive on consecutive cycles.
  - blk_plane=1 block equals the repeating 256-bit pattern 0101... with MSB=0 (bit0 of pixels 0..255).
  - Block keys run 22'b1101001110000110010001 for plane 1, through 22'b1101001110000110011000 for plane 8.
  - blk_idx=0 throughout.
- Backpressure: same run, toggle blk_ready 0/1 every 2 cycles -> blk and blk_plane are held while stalled, no plane is skipped or duplicated, and pix_ready stays 0 until plane 8 is accepted.
- Key latch: change key_in at pixel 100 of block 0 and again at block 5 -> every block in the frame carries the key sampled at the first pixel of block 0.
- Full frame: feed 65536 random pixels with blk_ready=1. Required response:
  - 2048 blocks are emitted.
  - blk_idx runs 0..255.
  - frame_done pulses exactly once, on the cycle after block 255 plane 8 is accepted.
  - Reassembling the planes reproduces the input pixels bit-exact.
- Reset mid-operation: assert rst_n=0 during EMIT at plane 4 -> blk_valid drops to 0 the next cycle; the following 256 pixels yield a fresh block with blk_idx=0 and plane 1 first.
